// File: rtl/aes_encrypt_arbiter.sv
// aes_encrypt_arbiter: round-robin share of one combinational AES encrypt core among N_REQ requesters.
// Latency: grant in cycle T, rsp_valid from T+SETTLE+1; best case one block every SETTLE+2 cycles.
// Backpressure: rsp_ready low holds DONE and the response stable; no request is granted until it drains.
module aes_encrypt_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int KEY_LEN = 128,
  parameter int Nr      = 10,
  parameter int Nk      = 4,
  parameter int SETTLE  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*128-1:0]     req_data,
  input  logic [N_REQ*KEY_LEN-1:0] req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [127:0]             rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    last;
  logic [ID_W-1:0]    op_id;
  logic [ID_W-1:0]    grant_id;
  logic [127:0]       op_data;
  logic [127:0]       sel_data;
  logic [127:0]       cipher;
  logic [KEY_LEN-1:0] op_key;
  logic [KEY_LEN-1:0] sel_key;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   rot;
  logic               grant_any;
  logic               settled;
  logic               rsp_fire;
  int                 idx;

  // ---------------------------------------------------------------- AES core
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full cipher: key expansion then Nr rounds; byte 0 of the block is the MSB
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KEY_LEN-1:0] k);
    logic [31:0]  w [4*(Nr+1)];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < Nk; i++) w[i] = k[KEY_LEN-1-32*i -: 32];
    for (int i = Nk; i < 4*(Nr+1); i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= Nr; r++) begin
      for (int b = 0; b < 16; b++) st[b] = sbox(st[b]);
      // row rw of column c takes the byte from column c+rw
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          sh[4*c+rw] = st[4*((c+rw)%4)+rw];
      for (int c = 0; c < 4; c++) begin
        a0 = sh[4*c];
        a1 = sh[4*c+1];
        a2 = sh[4*c+2];
        a3 = sh[4*c+3];
        if (r != Nr) begin
          st[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          st[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          st[4*c]   = a0;
          st[4*c+1] = a1;
          st[4*c+2] = a2;
          st[4*c+3] = a3;
        end
      end
      for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
    return res;
  endfunction

  // Core sees only the operand registers, so its inputs are stable through RUN
  always_comb begin
    cipher = encrypt(op_data, op_key);
  end

  // ---------------------------------------------------------------- arbiter
  // Round-robin pick: search starts one past the last served requester
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    rot       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      rot = req_valid >> idx;
      if (!grant_any && rot[0]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
        grant     = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data[i*128 +: 128];
        sel_key  = sel_key  | req_key[i*KEY_LEN +: KEY_LEN];
      end
    end
  end

  assign settled  = (cnt == CNT_W'(SETTLE - 1));
  assign rsp_fire = rsp_valid && rsp_ready;
  assign busy     = (state != IDLE);

  // ---------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and grant output; grant only exists in IDLE and never under reset
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_next = RUN;
          req_ready  = grant;
        end
      end
      RUN:     if (settled)  state_next = DONE;
      DONE:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) req_ready = '0;
  end

  // Operand capture, settle counter and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      last      <= ID_W'(N_REQ - 1);
      op_data   <= '0;
      op_key    <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_data <= sel_data;
            op_key  <= sel_key;
            op_id   <= grant_id;
            last    <= grant_id;
            cnt     <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (settled) begin
            rsp_data  <= cipher;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_fire) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// Directed bench for aes_encrypt_arbiter: FIPS-197 vectors, round-robin order,
// back-pressure, wider keys, reset mid-transaction and withdrawn requests.
module tb_aes_encrypt_arbiter;

  localparam logic [127:0] P0   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C0   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // 128-bit instance
  logic [1:0]   req_valid, req_ready;
  logic [255:0] req_data, req_key;
  logic         rsp_valid, rsp_ready, busy;
  logic [127:0] rsp_data;
  logic [0:0]   rsp_id;

  // 192-bit instance
  logic [1:0]   w192_valid, w192_ready;
  logic [255:0] w192_data;
  logic [383:0] w192_key;
  logic         w192_rsp_valid, w192_rsp_ready, w192_busy;
  logic [127:0] w192_rsp_data;
  logic [0:0]   w192_rsp_id;

  // 256-bit instance
  logic [1:0]   w256_valid, w256_ready;
  logic [255:0] w256_data;
  logic [511:0] w256_key;
  logic         w256_rsp_valid, w256_rsp_ready, w256_busy;
  logic [127:0] w256_rsp_data;
  logic [0:0]   w256_rsp_id;

  aes_encrypt_arbiter #(.N_REQ(2), .ID_W(1), .KEY_LEN(128), .Nr(10), .Nk(4), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy));

  aes_encrypt_arbiter #(.N_REQ(2), .ID_W(1), .KEY_LEN(192), .Nr(12), .Nk(6), .SETTLE(2)) dut192 (
    .clk(clk), .reset(reset), .req_valid(w192_valid), .req_ready(w192_ready),
    .req_data(w192_data), .req_key(w192_key), .rsp_valid(w192_rsp_valid), .rsp_ready(w192_rsp_ready),
    .rsp_data(w192_rsp_data), .rsp_id(w192_rsp_id), .busy(w192_busy));

  aes_encrypt_arbiter #(.N_REQ(2), .ID_W(1), .KEY_LEN(256), .Nr(14), .Nk(8), .SETTLE(2)) dut256 (
    .clk(clk), .reset(reset), .req_valid(w256_valid), .req_ready(w256_ready),
    .req_data(w256_data), .req_key(w256_key), .rsp_valid(w256_rsp_valid), .rsp_ready(w256_rsp_ready),
    .rsp_data(w256_rsp_data), .rsp_id(w256_rsp_id), .busy(w256_busy));

  // Pulse reset for one edge; returns at a negedge with reset released
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    req_data = {P0, P1};
    req_key = {K0, K1};
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready actual=%b required=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid actual=%b required=0", rsp_valid); end
    checks++; if (rsp_data !== 128'h0) begin failures++; $display("FAIL reset_rsp_data actual=%h required=0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id actual=%h required=0", rsp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (w256_rsp_data !== 128'h0) begin failures++; $display("FAIL reset_w256_rsp_data actual=%h required=0", w256_rsp_data); end
    reset = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01;
    req_data = {128'h0, P0};
    req_key = {128'h0, K0};
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant actual=%b required=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    req_data = '1;
    req_key = '1;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_run actual=%b required=1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_early1 actual=%b required=0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_early2 actual=%b required=0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid actual=%b required=1", rsp_valid); end
    checks++; if (rsp_data !== C0) begin failures++; $display("FAIL single_rsp_data actual=%h required=%h", rsp_data, C0); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_rsp_id actual=%h required=0", rsp_id); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done actual=%b required=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_clear actual=%b required=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int           n;
    int           multi;
    int           ids [4];
    logic [127:0] dat [4];
    int           at  [4];
    n = 0;
    multi = 0;
    do_reset();
    req_valid = 2'b11;
    req_data = {P0, P1};
    req_key = {K0, K1};
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (rsp_valid && n < 4) begin
        ids[n] = int'(rsp_id);
        dat[n] = rsp_data;
        at[n] = c;
        n++;
      end
      if (n == 4) begin
        req_valid = 2'b00;
        break;
      end
      @(negedge clk);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL rr_response_count actual=%0d required=4", n); end
    checks++; if (multi != 0) begin failures++; $display("FAIL rr_onehot actual=%0d multi-grant cycles required=0", multi); end
    for (int j = 0; j < n; j++) begin
      checks++; if (ids[j] != j % 2) begin failures++; $display("FAIL rr_id[%0d] actual=%0d required=%0d", j, ids[j], j % 2); end
      checks++; if (dat[j] !== ((j % 2 == 1) ? C0 : C1)) begin failures++; $display("FAIL rr_data[%0d] actual=%h required=%h", j, dat[j], (j % 2 == 1) ? C0 : C1); end
      checks++; if (at[j] != 3 + 4 * j) begin failures++; $display("FAIL rr_cycle[%0d] actual=%0d required=%0d", j, at[j], 3 + 4 * j); end
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    req_valid = 2'b11;
    req_data = {P0, P1};
    req_key = {K0, K1};
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant actual=%b required=01", req_ready); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid actual=%b required=1", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (rsp_data !== C1) begin failures++; $display("FAIL bp_hold_data[%0d] actual=%h required=%h", c, rsp_data, C1); end
      checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL bp_hold_id[%0d] actual=%h required=0", c, rsp_id); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_no_grant[%0d] actual=%b required=00", c, req_ready); end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_xfer_no_grant actual=%b required=00", req_ready); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_xfer_valid actual=%b required=1", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant actual=%b required=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin failures++; $display("FAIL bp_second_rsp actual=valid %b id %h required=valid 1 id 1", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== C0) begin failures++; $display("FAIL bp_second_data actual=%h required=%h", rsp_data, C0); end
  endtask

  task automatic test_wider_keys();
    @(negedge clk);
    w192_valid = 2'b01;
    w192_data = {128'h0, P1};
    w192_key = {192'h0, K192};
    w192_rsp_ready = 1'b1;
    w256_valid = 2'b01;
    w256_data = {128'h0, P1};
    w256_key = {256'h0, K256};
    w256_rsp_ready = 1'b1;
    #1;
    checks++; if (w192_ready !== 2'b01) begin failures++; $display("FAIL w192_grant actual=%b required=01", w192_ready); end
    checks++; if (w256_ready !== 2'b01) begin failures++; $display("FAIL w256_grant actual=%b required=01", w256_ready); end
    @(negedge clk);
    w192_valid = 2'b00;
    w256_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (w192_rsp_valid !== 1'b1) begin failures++; $display("FAIL w192_rsp_valid actual=%b required=1", w192_rsp_valid); end
    checks++; if (w192_rsp_data !== C192) begin failures++; $display("FAIL w192_rsp_data actual=%h required=%h", w192_rsp_data, C192); end
    checks++; if (w256_rsp_valid !== 1'b1) begin failures++; $display("FAIL w256_rsp_valid actual=%b required=1", w256_rsp_valid); end
    checks++; if (w256_rsp_data !== C256) begin failures++; $display("FAIL w256_rsp_data actual=%h required=%h", w256_rsp_data, C256); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_valid = 2'b01;
    req_data = {P0, P1};
    req_key = {K0, K1};
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_pre_grant actual=%b required=01", req_ready); end
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_rsp[%0d] actual=%b required=0", c, rsp_valid); end
      checks++; if (rsp_data !== 128'h0) begin failures++; $display("FAIL rst_rsp_data[%0d] actual=%h required=0", c, rsp_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy[%0d] actual=%b required=0", c, busy); end
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant actual=%b required=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin failures++; $display("FAIL rst_after_rsp actual=valid %b id %h required=valid 1 id 0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== C1) begin failures++; $display("FAIL rst_after_data actual=%h required=%h", rsp_data, C1); end
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL wd_done1 actual=ready %b busy %b required=ready 00 busy 1", req_ready, busy); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL wd_done2 actual=%b required=00", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b1) begin failures++; $display("FAIL wd_xfer actual=ready %b valid %b required=ready 00 valid 1", req_ready, rsp_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_idle_busy[%0d] actual=%b required=0", c, busy); end
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL wd_idle[%0d] actual=valid %b ready %b required=valid 0 ready 00", c, rsp_valid, req_ready); end
    end
    checks++; if (rsp_data !== C1) begin failures++; $display("FAIL wd_data_kept actual=%h required=%h", rsp_data, C1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_data = '0;
    req_key = '0;
    rsp_ready = 1'b1;
    w192_valid = 2'b00;
    w192_data = '0;
    w192_key = '0;
    w192_rsp_ready = 1'b1;
    w256_valid = 2'b00;
    w256_data = '0;
    w256_key = '0;
    w256_rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_wider_keys();
    test_reset_mid_run();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_arbiter.md
# aes_encrypt_arbiter

Shares one combinational `AES_Encrypt` core between `N_REQ` requesters. Uses round-robin arbitration, a valid/ready request and response handshake, and a fixed settle window. Operands are registered into the core, held stable for `SETTLE` cycles, and the ciphertext is captured into a response register tagged with the requester index. The block sits between the block-cipher users (packet engines, key-wrap logic) and the single shared encrypt instance.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `ID_W`, 1: width of `rsp_id`; must satisfy 2^ID_W >= N_REQ.
- `KEY_LEN`, 128: key width; passed to the core (128/192/256).
- `Nr`, 10: round count; passed to the core (10/12/14).
- `Nk`, 4: key words; passed to the core (4/6/8).
- `SETTLE`, 2: cycles operands are held before the core output is sampled (>=1).

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_ready`, out, N_REQ: one-hot grant/accept.
- `req_data`, in, N_REQ*128: plaintexts; requester i at [i*128 +: 128].
- `req_key`, in, N_REQ*KEY_LEN: keys; requester i at [i*KEY_LEN +: KEY_LEN].
- `rsp_valid`, out, 1: ciphertext available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, 128: ciphertext.
- `rsp_id`, out, ID_W: index of the requester that owns `rsp_data`.
- `busy`, out, 1: high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - If any `req_valid` is high, grant one requester by round-robin: the search starts at `last+1` and wraps modulo N_REQ.
  - `req_ready[g]` is high combinationally in this cycle for the granted index g only. The transfer completes in the same cycle.
  - On the clock edge: latch `req_data[g]` into `op_data`, `req_key[g]` into `op_key`, g into `op_id` and `last`; clear `cnt`; go to RUN.
  - If no request is valid, stay in IDLE; `req_ready` is all zeros.
- **RUN**
  - The core inputs are driven only from `op_data`/`op_key` and are stable for the whole state.
  - `cnt` increments each cycle.
  - When `cnt == SETTLE-1`: capture the core output into `rsp_data`, `op_id` into `rsp_id`, set `rsp_valid`, go to DONE.
  - `req_ready` is all zeros.
- **DONE**
  - `rsp_valid`, `rsp_data` and `rsp_id` are held stable until `rsp_ready` is high.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid` and go to IDLE. `rsp_data` keeps its last value.
  - `req_ready` is all zeros; there is no grant in the same cycle as a response transfer.
- **Fairness:** after requester i is served, i has the lowest priority at the next grant. With all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
- **Requester handshake rules:**
  - A requester may deassert `req_valid` before it is granted; no state changes.
  - `req_data`/`req_key` only need to be valid in the grant cycle.
- **`busy`** equals (state != IDLE).

## Timing
- **Reset (`reset` high at an edge):**
  - state becomes IDLE, `cnt` becomes 0, `last` becomes N_REQ-1 (so requester 0 wins first).
  - `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `op_data`/`op_key`/`op_id` 0.
  - `req_ready` is forced all-zero while `reset` is high, independent of state.
- **Reset mid-operation** (in RUN or DONE): the transaction is discarded, no response is produced, and the requester is not notified.
- **Latency:**
  - Grant at cycle T.
  - `rsp_valid` first high in cycle T+SETTLE+1.
  - Earliest next grant is at cycle T+SETTLE+2, when `rsp_ready` is already high in T+SETTLE+1.
  - Peak throughput is one block per SETTLE+2 cycles.
- **Back-pressure:** `rsp_ready` low stalls DONE indefinitely. No request is accepted while stalled.
- **Simultaneous requests:** exactly one grant per IDLE cycle; at most one `req_ready` bit is ever high.
- **Core timing:** the core output path from `op_*` to `rsp_data` is a SETTLE-cycle multicycle path; no other logic samples the core output.

## Test plan
- **Single request, 128-bit:**
  - Stimulus: N_REQ=2, SETTLE=2. Requester 0 sends data `3243f6a8885a308d313198a2e0370734` with key `2b7e151628aed2a6abf7158809cf4f3c`; `rsp_ready`=1.
  - Required: `req_ready[0]`=1 in cycle T. `rsp_valid` rises in T+3 with `rsp_data`=`3925841d02dc09fbdc118597196a0b32`, `rsp_id`=0. `busy` is low again in T+4.
- **Round-robin:**
  - Stimulus: both requesters held valid. Requester 0 uses key `000102030405060708090a0b0c0d0e0f`, data `00112233445566778899aabbccddeeff`. Requester 1 uses the first test's vector.
  - Required: `rsp_id` sequence is 0,1,0,1. Responses are `69c4e0d86a7b0430d8cdb78070b4c55a` and `3925841d02dc09fbdc118597196a0b32`, alternating. Never two `req_ready` bits high at once.
- **Back-pressure:**
  - Stimulus: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` rises, with requester 1 valid throughout.
  - Required: `rsp_data`/`rsp_id` stable across the 10 cycles; `req_ready[1]` stays 0 until the cycle after the transfer.
- **Wider keys:**
  - Stimulus: parameter sets (192,12,6) and (256,14,8), data `00112233445566778899aabbccddeeff`, keys `000102…17` and `000102…1f`.
  - Required: `rsp_data` = `dda97ca4864cdfe06eaf70a0ec0d7191` for 192-bit and `8ea2b7ca516745bfeafc49904b496089` for 256-bit.
- **Reset mid-RUN:**
  - Stimulus: assert `reset` one cycle after a grant.
  - Required: `rsp_valid` stays 0 with no response; `rsp_data`=0. After release, the first grant goes to requester 0 when both requesters are valid.
- **Withdrawn request:**
  - Stimulus: requester 1 pulses `req_valid` while the block is in DONE, then deasserts it before DONE exits.
  - Required: no grant to requester 1; the block returns to IDLE with `busy`=0.
